// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/multiply pipeline: opcodes, flag bit positions
// and small decode helpers used by both the top level and the multiply core.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } aluOp_e;

  typedef enum logic [2:0] {
    MOP_MUL   = 3'b000,
    MOP_MLA   = 3'b001,
    MOP_UMULL = 3'b100,
    MOP_UMLAL = 3'b101,
    MOP_SMULL = 3'b110,
    MOP_SMLAL = 3'b111
  } mulOp_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  function automatic logic isTestOp(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Illegal encodings (010, 011) fall out of all three tests and so run as plain MUL.
  function automatic logic mulIsLong(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic mulIsAcc(input logic [2:0] op);
    return (op == MOP_MLA) || (op == MOP_UMLAL) || (op == MOP_SMLAL);
  endfunction

  function automatic logic mulIsSigned(input logic [2:0] op);
    return (op == MOP_SMULL) || (op == MOP_SMLAL);
  endfunction

endpackage

// File: rtl/mul_iter_core.sv
// Iterative multiply-accumulate core: consumes MUL_STEP multiplier bits per
// cycle and presents the final sum combinationally while done is high.
module mul_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [2:0]           i_mulOp,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [WIDTH-1:0]     i_accLo,
  input  logic [WIDTH-1:0]     i_accHi,
  input  logic                 i_ack,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int ITERS = WIDTH / MUL_STEP;
  localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic               w_signed;
  logic [2*WIDTH-1:0] w_aExt;
  logic [2*WIDTH-1:0] w_accIn;
  logic [2*WIDTH-1:0] w_corr;
  logic [2*WIDTH-1:0] w_partial;

  // The multiplier is walked as unsigned digits; a negative signed multiplier is
  // fixed up by pre-subtracting a<<WIDTH from the starting accumulator.
  always_comb begin
    w_signed = mulIsSigned(i_mulOp);
    w_aExt   = w_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
    w_accIn  = '0;
    if (mulIsAcc(i_mulOp)) begin
      w_accIn = mulIsLong(i_mulOp) ? {i_accHi, i_accLo} : {{WIDTH{1'b0}}, i_accLo};
    end
    w_corr = (w_signed && i_b[WIDTH-1]) ? {i_a, {WIDTH{1'b0}}} : '0;
  end

  always_comb begin
    w_partial = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (r_mplier[k]) begin
        w_partial = w_partial + (r_mcand << k);
      end
    end
  end

  // The last digit is folded into o_product instead of registered, so the
  // core sits at LAST with done asserted until the result is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= w_aExt;
      r_mplier <= i_b;
      r_acc    <= w_accIn - w_corr;
    end else if (r_busy) begin
      if (r_cnt != LAST) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << MUL_STEP;
        r_mplier <= r_mplier >> MUL_STEP;
        r_cnt    <= r_cnt + CW'(1);
      end else if (i_ack) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = r_acc + w_partial;

endmodule

// File: rtl/alu_mul_pipe.sv
// ARM data-processing ALU with an iterative multiplier behind a valid/ready
// input and a held output register drained by writeback.
module alu_mul_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic             isMul,
  input  logic [3:0]       aluOp,
  input  logic [2:0]       mulOp,
  input  logic [WIDTH-1:0] aBus,
  input  logic [WIDTH-1:0] barrelOutput,
  input  logic             shifterCarry,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] accHi,
  input  logic             updateFlags,
  input  logic [3:0]       flagsIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] resultLo,
  output logic [WIDTH-1:0] resultHi,
  output logic             writeResult,
  output logic             writeHi,
  output logic [3:0]       flagsOut
);

  logic [0:0]       r_state;
  logic             r_outValid;
  logic [WIDTH-1:0] r_resultLo;
  logic [WIDTH-1:0] r_resultHi;
  logic             r_writeResult;
  logic             r_writeHi;
  logic [3:0]       r_flags;
  logic             r_mulLong;
  logic             r_mulUpd;
  logic [3:0]       r_mulFlagsIn;

  aluOp_e             w_op;
  logic               w_outFree;
  logic               w_accept;
  logic               w_mulStart;
  logic               w_mulAck;
  logic               w_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_addX;
  logic [WIDTH-1:0]   w_addY;
  logic               w_cin;
  logic               w_isArith;
  logic [WIDTH-1:0]   w_logic;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_dataRes;
  logic [3:0]         w_dataFlags;
  logic [WIDTH-1:0]   w_mulHi;
  logic [3:0]         w_mulFlags;

  assign w_op       = aluOp_e'(aluOp);
  assign w_outFree  = !r_outValid || outReady;
  assign inReady    = (r_state == ST_IDLE) && w_outFree;
  assign w_accept   = inValid && inReady;
  assign w_mulStart = w_accept && isMul;
  assign w_mulAck   = (r_state == ST_MUL) && w_done && w_outFree;

  mul_iter_core #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mulCore (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_mulStart),
    .i_mulOp   (mulOp),
    .i_a       (aBus),
    .i_b       (barrelOutput),
    .i_accLo   (accLo),
    .i_accHi   (accHi),
    .i_ack     (w_mulAck),
    .o_done    (w_done),
    .o_product (w_product)
  );

  // All subtract forms reuse the one adder as x + ~y + carry-in, so C is NOT borrow.
  always_comb begin
    w_addX    = aBus;
    w_addY    = barrelOutput;
    w_cin     = 1'b0;
    w_isArith = 1'b1;
    case (w_op)
      OP_ADD, OP_CMN: w_cin = 1'b0;
      OP_ADC:         w_cin = flagsIn[FLAG_C];
      OP_SUB, OP_CMP: begin w_addY = ~barrelOutput; w_cin = 1'b1; end
      OP_SBC:         begin w_addY = ~barrelOutput; w_cin = flagsIn[FLAG_C]; end
      OP_RSB:         begin w_addX = barrelOutput; w_addY = ~aBus; w_cin = 1'b1; end
      OP_RSC:         begin w_addX = barrelOutput; w_addY = ~aBus; w_cin = flagsIn[FLAG_C]; end
      default:        w_isArith = 1'b0;
    endcase

    case (w_op)
      OP_AND, OP_TST: w_logic = aBus & barrelOutput;
      OP_EOR, OP_TEQ: w_logic = aBus ^ barrelOutput;
      OP_ORR:         w_logic = aBus | barrelOutput;
      OP_MOV:         w_logic = barrelOutput;
      OP_BIC:         w_logic = aBus & ~barrelOutput;
      OP_MVN:         w_logic = ~barrelOutput;
      default:        w_logic = '0;
    endcase

    w_sum     = {1'b0, w_addX} + {1'b0, w_addY} + {{WIDTH{1'b0}}, w_cin};
    w_dataRes = w_isArith ? w_sum[WIDTH-1:0] : w_logic;

    w_dataFlags         = '0;
    w_dataFlags[FLAG_N] = w_dataRes[WIDTH-1];
    w_dataFlags[FLAG_Z] = (w_dataRes == '0);
    w_dataFlags[FLAG_C] = w_isArith ? w_sum[WIDTH] : shifterCarry;
    w_dataFlags[FLAG_V] = w_isArith ?
                          ((w_addX[WIDTH-1] == w_addY[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != w_addX[WIDTH-1])) :
                          flagsIn[FLAG_V];
  end

  // Short multiplies judge N/Z on the low word only; C and V ride through.
  always_comb begin
    w_mulHi    = r_mulLong ? w_product[2*WIDTH-1:WIDTH] : '0;
    w_mulFlags = r_mulFlagsIn;
    w_mulFlags[FLAG_N] = r_mulLong ? w_product[2*WIDTH-1] : w_product[WIDTH-1];
    w_mulFlags[FLAG_Z] = r_mulLong ? (w_product == '0) : (w_product[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mulLong    <= 1'b0;
      r_mulUpd     <= 1'b0;
      r_mulFlagsIn <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mulStart) begin
            r_state      <= ST_MUL;
            r_mulLong    <= mulIsLong(mulOp);
            r_mulUpd     <= updateFlags;
            r_mulFlagsIn <= flagsIn;
          end
        end
        ST_MUL: begin
          if (w_mulAck) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A data op may reload the register in the same cycle writeback drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid    <= 1'b0;
      r_resultLo    <= '0;
      r_resultHi    <= '0;
      r_writeResult <= 1'b0;
      r_writeHi     <= 1'b0;
      r_flags       <= '0;
    end else if (w_accept && !isMul) begin
      r_outValid    <= 1'b1;
      r_resultLo    <= w_dataRes;
      r_resultHi    <= '0;
      r_writeResult <= !isTestOp(aluOp);
      r_writeHi     <= 1'b0;
      r_flags       <= updateFlags ? w_dataFlags : flagsIn;
    end else if (w_mulAck) begin
      r_outValid    <= 1'b1;
      r_resultLo    <= w_product[WIDTH-1:0];
      r_resultHi    <= w_mulHi;
      r_writeResult <= 1'b1;
      r_writeHi     <= r_mulLong;
      r_flags       <= r_mulUpd ? w_mulFlags : r_mulFlagsIn;
    end else if (outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign outValid    = r_outValid;
  assign resultLo    = r_resultLo;
  assign resultHi    = r_resultHi;
  assign writeResult = r_writeResult;
  assign writeHi     = r_writeHi;
  assign flagsOut    = r_flags;

endmodule

// File: tb/tb_alu_mul_pipe.sv
// Scoreboard bench for alu_mul_pipe: directed ops push expected results, a
// negedge monitor pops and compares each result as writeback consumes it.
module tb_alu_mul_pipe;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        wr;
    logic        wh;
    logic [3:0]  fl;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic        isMul;
  logic [3:0]  aluOp;
  logic [2:0]  mulOp;
  logic [31:0] aBus;
  logic [31:0] barrelOutput;
  logic        shifterCarry;
  logic [31:0] accLo;
  logic [31:0] accHi;
  logic        updateFlags;
  logic [3:0]  flagsIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] resultLo;
  logic [31:0] resultHi;
  logic        writeResult;
  logic        writeHi;
  logic [3:0]  flagsOut;

  expect_t sbq[$];
  int      nChecks = 0;
  int      nFails  = 0;
  int      cycle   = 0;

  alu_mul_pipe #(.WIDTH(32), .MUL_STEP(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .isMul        (isMul),
    .aluOp        (aluOp),
    .mulOp        (mulOp),
    .aBus         (aBus),
    .barrelOutput (barrelOutput),
    .shifterCarry (shifterCarry),
    .accLo        (accLo),
    .accHi        (accHi),
    .updateFlags  (updateFlags),
    .flagsIn      (flagsIn),
    .outValid     (outValid),
    .outReady     (outReady),
    .resultLo     (resultLo),
    .resultHi     (resultHi),
    .writeResult  (writeResult),
    .writeHi      (writeHi),
    .flagsOut     (flagsOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic expect_t mkExp(input string t, input logic [31:0] lo, input logic [31:0] hi,
                                    input logic wr, input logic wh, input logic [3:0] fl);
    expect_t e;
    e.tag = t; e.lo = lo; e.hi = hi; e.wr = wr; e.wh = wh; e.fl = fl;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, act, req);
    end
  endtask

  // Presents one op, waits (bounded) for acceptance, then scrambles the inputs.
  task automatic applyStimulus(input logic mul, input logic [3:0] aop, input logic [2:0] mop,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] aL, input logic [31:0] aH,
                               input logic sc, input logic upd, input logic [3:0] fin,
                               input logic expectOut, input expect_t e, output int acc);
    int guard = 0;
    isMul = mul; aluOp = aop; mulOp = mop; aBus = a; barrelOutput = b;
    accLo = aL; accHi = aH; shifterCarry = sc; updateFlags = upd; flagsIn = fin;
    inValid = 1'b1;
    #1;
    while (!inReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!inReady) begin
      nChecks++; nFails++;
      $display("[TB] FAIL %s.accept: got inReady 0 for %0d cycles, required 1", e.tag, guard);
      inValid = 1'b0;
      acc = -1;
      return;
    end
    if (expectOut) sbq.push_back(e);
    @(posedge clk); #1;
    acc = cycle;
    inValid = 1'b0; isMul = ~mul; aluOp = ~aop; mulOp = ~mop;
    aBus = 32'hDEADBEEF; barrelOutput = 32'hBADC0FFE; accLo = 32'h13572468;
    accHi = 32'h24681357; shifterCarry = ~sc; updateFlags = ~upd; flagsIn = ~fin;
  endtask

  task automatic waitOut(output int n);
    n = 0;
    while (!outValid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq.size() != 0 || outValid) && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("drain", 64'(sbq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (!reset && outValid && outReady) begin
      if (sbq.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL unexpected_output: got resultLo 0x%0h, required no output", resultLo);
      end else begin
        e = sbq.pop_front();
        checkOutput({e.tag, ".lo"}, 64'(resultLo), 64'(e.lo));
        if (e.wh) checkOutput({e.tag, ".hi"}, 64'(resultHi), 64'(e.hi));
        checkOutput({e.tag, ".writeResult"}, 64'(writeResult), 64'(e.wr));
        checkOutput({e.tag, ".writeHi"}, 64'(writeHi), 64'(e.wh));
        checkOutput({e.tag, ".flags"}, 64'(flagsOut), 64'(e.fl));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0, acc1, n;
    expect_t none;
    none = mkExp("none", 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    reset = 1'b1; inValid = 1'b0; outReady = 1'b1; isMul = 1'b0; aluOp = 4'h0; mulOp = 3'h0;
    aBus = '0; barrelOutput = '0; shifterCarry = 1'b0; accLo = '0; accHi = '0;
    updateFlags = 1'b0; flagsIn = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.outValid", 64'(outValid), 64'd0);
    checkOutput("reset.resultLo", 64'(resultLo), 64'd0);
    checkOutput("reset.resultHi", 64'(resultHi), 64'd0);
    checkOutput("reset.writeResult", 64'(writeResult), 64'd0);
    checkOutput("reset.writeHi", 64'(writeHi), 64'd0);
    checkOutput("reset.flags", 64'(flagsOut), 64'd0);
    checkOutput("reset.inReady", 64'(inReady), 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b0, OP_SUB, 3'b000, 32'd5, 32'd7, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("sub", 32'hFFFFFFFE, 0, 1'b1, 1'b0, 4'b1000), acc0);
    checkOutput("sub.latency", 64'(outValid), 64'd1);
    applyStimulus(1'b0, OP_ADD, 3'b000, 32'h7FFFFFFF, 32'd1, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("adds", 32'h80000000, 0, 1'b1, 1'b0, 4'b1001), acc0);
    applyStimulus(1'b0, OP_MOV, 3'b000, 32'h1234, 32'd0, 0, 0, 1'b1, 1'b1, 4'b1001, 1'b1,
                  mkExp("movs", 32'h0, 0, 1'b1, 1'b0, 4'b0111), acc0);

    applyStimulus(1'b1, 4'h0, MOP_SMLAL, 32'hFFFFFFFE, 32'd3, 32'd10, 32'd0, 1'b0, 1'b1, 4'b0011, 1'b1,
                  mkExp("smlal", 32'h4, 32'h0, 1'b1, 1'b1, 4'b0011), acc0);
    waitOut(n);
    checkOutput("smlal.latency", 64'(n), 64'd4);
    drain();

    // UMULL completes while writeback is stalled; result must sit still.
    outReady = 1'b0;
    applyStimulus(1'b1, 4'h0, MOP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h6, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("umull", 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b1, 4'b1000), acc0);
    checkOutput("umull.busy_inReady", 64'(inReady), 64'd0);
    waitOut(n);
    checkOutput("umull.latency", 64'(n), 64'd4);
    for (int i = 0; i < 3; i++) begin
      checkOutput("umull.stall_valid", 64'(outValid), 64'd1);
      checkOutput("umull.stall_lo", 64'(resultLo), 64'h00000001);
      checkOutput("umull.stall_hi", 64'(resultHi), 64'hFFFFFFFE);
      checkOutput("umull.stall_inReady", 64'(inReady), 64'd0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    drain();

    applyStimulus(1'b0, OP_CMP, 3'b000, 32'd9, 32'd9, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("cmp", 32'h0, 0, 1'b0, 1'b0, 4'b0110), acc0);
    checkOutput("cmp.latency", 64'(outValid), 64'd1);
    applyStimulus(1'b0, OP_AND, 3'b000, 32'hF0F0, 32'hFF00, 0, 0, 1'b0, 1'b0, 4'b0101, 1'b1,
                  mkExp("and", 32'hF000, 0, 1'b1, 1'b0, 4'b0101), acc1);
    applyStimulus(1'b0, OP_EOR, 3'b000, 32'hFF, 32'h0F, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("eor", 32'hF0, 0, 1'b1, 1'b0, 4'b0000), acc1);
    applyStimulus(1'b0, OP_RSB, 3'b000, 32'd1, 32'd10, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("rsb", 32'd9, 0, 1'b1, 1'b0, 4'b0010), acc1);
    applyStimulus(1'b0, OP_ADC, 3'b000, 32'hFFFFFFFF, 32'd0, 0, 0, 1'b0, 1'b1, 4'b0010, 1'b1,
                  mkExp("adc", 32'h0, 0, 1'b1, 1'b0, 4'b0110), acc1);
    applyStimulus(1'b0, OP_SBC, 3'b000, 32'd5, 32'd3, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("sbc", 32'd1, 0, 1'b1, 1'b0, 4'b0010), acc1);
    applyStimulus(1'b0, OP_RSC, 3'b000, 32'd3, 32'd5, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("rsc", 32'd1, 0, 1'b1, 1'b0, 4'b0010), acc1);
    applyStimulus(1'b0, OP_MVN, 3'b000, 32'd0, 32'd0, 0, 0, 1'b0, 1'b1, 4'b0001, 1'b1,
                  mkExp("mvn", 32'hFFFFFFFF, 0, 1'b1, 1'b0, 4'b1001), acc1);
    applyStimulus(1'b0, OP_BIC, 3'b000, 32'hFF, 32'h0F, 0, 0, 1'b0, 1'b0, 4'b1111, 1'b1,
                  mkExp("bic", 32'hF0, 0, 1'b1, 1'b0, 4'b1111), acc1);
    applyStimulus(1'b0, OP_TEQ, 3'b000, 32'hAA, 32'hAA, 0, 0, 1'b1, 1'b1, 4'b0000, 1'b1,
                  mkExp("teq", 32'h0, 0, 1'b0, 1'b0, 4'b0110), acc1);
    applyStimulus(1'b0, OP_CMN, 3'b000, 32'hFFFFFFFF, 32'd1, 0, 0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("cmn", 32'h0, 0, 1'b0, 1'b0, 4'b0110), acc1);
    applyStimulus(1'b0, OP_ORR, 3'b000, 32'd1, 32'd2, 0, 0, 1'b0, 1'b0, 4'b1010, 1'b1,
                  mkExp("orr", 32'd3, 0, 1'b1, 1'b0, 4'b1010), acc1);
    checkOutput("b2b.throughput", 64'(acc1 - acc0), 64'd11);

    applyStimulus(1'b1, 4'h0, MOP_MLA, 32'd7, 32'd6, 32'd100, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("mla", 32'h8E, 0, 1'b1, 1'b0, 4'b0000), acc0);
    applyStimulus(1'b1, 4'h0, 3'b011, 32'd3, 32'd4, 32'd1000, 32'd7, 1'b0, 1'b1, 4'b0110, 1'b1,
                  mkExp("illegal_mul", 32'hC, 0, 1'b1, 1'b0, 4'b0010), acc0);
    applyStimulus(1'b1, 4'h0, MOP_MUL, 32'h10000, 32'h10000, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("mul_zero", 32'h0, 0, 1'b1, 1'b0, 4'b0100), acc0);
    drain();

    // Abort a multiply with reset two cycles in; nothing may come out of it.
    applyStimulus(1'b1, 4'h0, MOP_UMULL, 32'h1234, 32'h5678, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0,
                  none, acc0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checkOutput("abort.outValid", 64'(outValid), 64'd0);
    checkOutput("abort.resultLo", 64'(resultLo), 64'd0);
    checkOutput("abort.resultHi", 64'(resultHi), 64'd0);
    checkOutput("abort.writeResult", 64'(writeResult), 64'd0);
    checkOutput("abort.writeHi", 64'(writeHi), 64'd0);
    checkOutput("abort.flags", 64'(flagsOut), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    checkOutput("abort.no_output", 64'(outValid), 64'd0);

    applyStimulus(1'b1, 4'h0, MOP_SMULL, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1,
                  mkExp("smull", 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b1, 4'b1000), acc0);
    waitOut(n);
    checkOutput("smull.latency", 64'(n), 64'd4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
